// File: rtl/riscv_v_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_v_pkg
//  Description : Shared types and helpers for the elastic (valid/ready)
//                pipeline stage and its skid slots.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_v_pkg;

  // Slot occupancy states: EMPTY holds nothing, BUSY holds one beat in the
  // main register, FULL additionally holds one beat in the skid register.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Number of beats held by a slot in the given state.
  function automatic logic [1:0] skid_cnt(skid_state_t st);
    logic [1:0] cnt;
    case (st)
      SKID_BUSY: cnt = 2'd1;
      SKID_FULL: cnt = 2'd2;
      default:   cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_v_elastic_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_v_elastic_stage_if
//  Description : Valid/ready/data stream bundle. The master drives valid and
//                data, the slave drives ready.
//  Revision    : 1.0  initial release
// ============================================================================
interface riscv_v_elastic_stage_if #(
  parameter int DATA_W = 32
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface
`default_nettype wire

// File: rtl/riscv_v_skid_slot.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_v_skid_slot
//  Description : One 2-entry skid slot. in_ready depends only on the state
//                register, so no combinational path runs from out_ready back
//                to in_ready. Main register M always presents the oldest beat.
//  Revision    : 1.0  initial release
// ============================================================================
module riscv_v_skid_slot
  import riscv_v_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              flush,
  input  wire logic [DATA_W-1:0] rst_val,
  input  wire logic [DATA_W-1:0] flush_val,
  input  wire logic              in_valid,
  output logic                   in_ready,
  input  wire logic [DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  wire logic              out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             cnt
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = (state_q != SKID_FULL);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = m_q;
  assign cnt       = skid_cnt(state_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next state and register loads; registers not loaded keep their value.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d = SKID_BUSY;
          m_d     = in_data;
        end
      end
      SKID_BUSY: begin
        if (in_fire && !out_fire) begin
          // Downstream stalled: park the new beat behind the current one.
          state_d = SKID_FULL;
          s_d     = in_data;
        end else if (!in_fire && out_fire) begin
          state_d = SKID_EMPTY;
        end else if (in_fire && out_fire) begin
          m_d     = in_data;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (out_fire) begin
          state_d = SKID_BUSY;
          m_d     = s_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // State and data registers: async reset, then sync flush, then normal load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      m_q     <= rst_val;
      s_q     <= rst_val;
    end else if (flush) begin
      state_q <= SKID_EMPTY;
      m_q     <= flush_val;
      s_q     <= flush_val;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_v_elastic_stage.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_v_elastic_stage
//  Description : Elastic valid/ready pipeline stage built from NUM_STAGES
//                chained skid slots. Capacity 2*NUM_STAGES beats, strict
//                FIFO order, full throughput, registered in_ready.
//  Revision    : 1.0  initial release
// ============================================================================
module riscv_v_elastic_stage
  import riscv_v_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 1,
  localparam int OCC_W     = $clog2(2*NUM_STAGES+1)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              flush,
  input  wire logic [DATA_W-1:0] rst_val,
  input  wire logic [DATA_W-1:0] flush_val,
  riscv_v_elastic_stage_if.slave  up,
  riscv_v_elastic_stage_if.master dn,
  output logic [OCC_W-1:0]       occupancy
);

  // Link k is the interface entering slot k; link NUM_STAGES is the output.
  logic              link_valid [NUM_STAGES+1];
  logic              link_ready [NUM_STAGES+1];
  logic [DATA_W-1:0] link_data  [NUM_STAGES+1];
  logic [1:0]        slot_cnt   [NUM_STAGES];
  logic [OCC_W-1:0]  occ_sum;

  assign link_valid[0]          = up.valid;
  assign link_data[0]           = up.data;
  assign up.ready               = link_ready[0];
  assign dn.valid               = link_valid[NUM_STAGES];
  assign dn.data                = link_data[NUM_STAGES];
  assign link_ready[NUM_STAGES] = dn.ready;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slot
    riscv_v_skid_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .rst_val   (rst_val),
      .flush_val (flush_val),
      .in_valid  (link_valid[k]),
      .in_ready  (link_ready[k]),
      .in_data   (link_data[k]),
      .out_valid (link_valid[k+1]),
      .out_ready (link_ready[k+1]),
      .out_data  (link_data[k+1]),
      .cnt       (slot_cnt[k])
    );
  end

  // Total beats held: sum of per-slot counts, all taken from state flops.
  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      occ_sum = occ_sum + OCC_W'(slot_cnt[k]);
    end
  end

  assign occupancy = occ_sum;

endmodule
`default_nettype wire

// File: tb/tb_riscv_v_elastic_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_v_elastic_stage
//  Description : Self-checking bench. Three chains (1, 2 and 3 slots) share
//                one stimulus; each is checked every cycle against a model
//                that treats every slot as a 2-deep buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_riscv_v_elastic_stage;

  localparam logic [31:0] RST_VAL   = 32'h0000_DEAD;
  localparam logic [31:0] FLUSH_VAL = 32'hF1F1_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic [31:0] rst_val = RST_VAL;
  logic [31:0] flush_val = FLUSH_VAL;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit seen55 = 1'b0;
  logic [31:0] got2 [$];

  always #5 clk = ~clk;

  riscv_v_elastic_stage_if #(.DATA_W(32)) up1 ();
  riscv_v_elastic_stage_if #(.DATA_W(32)) dn1 ();
  riscv_v_elastic_stage_if #(.DATA_W(32)) up2 ();
  riscv_v_elastic_stage_if #(.DATA_W(32)) dn2 ();
  riscv_v_elastic_stage_if #(.DATA_W(32)) up3 ();
  riscv_v_elastic_stage_if #(.DATA_W(32)) dn3 ();

  assign up1.valid = in_valid;  assign up1.data = in_data;  assign dn1.ready = out_ready;
  assign up2.valid = in_valid;  assign up2.data = in_data;  assign dn2.ready = out_ready;
  assign up3.valid = in_valid;  assign up3.data = in_data;  assign dn3.ready = out_ready;

  logic [1:0] occ1;
  logic [2:0] occ2;
  logic [2:0] occ3;

  riscv_v_elastic_stage #(.DATA_W(32), .NUM_STAGES(1)) u_ns1 (
    .clk(clk), .rst(rst), .flush(flush), .rst_val(rst_val), .flush_val(flush_val),
    .up(up1.slave), .dn(dn1.master), .occupancy(occ1));
  riscv_v_elastic_stage #(.DATA_W(32), .NUM_STAGES(2)) u_ns2 (
    .clk(clk), .rst(rst), .flush(flush), .rst_val(rst_val), .flush_val(flush_val),
    .up(up2.slave), .dn(dn2.master), .occupancy(occ2));
  riscv_v_elastic_stage #(.DATA_W(32), .NUM_STAGES(3)) u_ns3 (
    .clk(clk), .rst(rst), .flush(flush), .rst_val(rst_val), .flush_val(flush_val),
    .up(up3.slave), .dn(dn3.master), .occupancy(occ3));

  logic        rdy_a [3];
  logic        ov_a  [3];
  logic [31:0] od_a  [3];
  logic [31:0] occ_a [3];
  assign rdy_a[0] = up1.ready;  assign ov_a[0] = dn1.valid;  assign od_a[0] = dn1.data;
  assign rdy_a[1] = up2.ready;  assign ov_a[1] = dn2.valid;  assign od_a[1] = dn2.data;
  assign rdy_a[2] = up3.ready;  assign ov_a[2] = dn3.valid;  assign od_a[2] = dn3.data;
  assign occ_a[0] = {30'b0, occ1};
  assign occ_a[1] = {29'b0, occ2};
  assign occ_a[2] = {29'b0, occ3};

  // Model: per chain c, per slot k, a buffer of up to two beats (oldest at
  // index 0) plus the last value the slot presented on its output.
  logic [31:0] mbuf  [3][3][2];
  int          msz   [3][3];
  logic [31:0] mlast [3][3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear(input logic [31:0] v);
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 3; k++) begin
        msz[c][k]   = 0;
        mlast[c][k] = v;
      end
  endtask

  function automatic int model_occ(input int c);
    int t = 0;
    for (int k = 0; k < 3; k++) t += msz[c][k];
    return t;
  endfunction

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_step();
    int          s [3];
    bit          f [4];
    logic [31:0] d [4];
    int          n;
    if (flush) begin
      model_clear(flush_val);
      return;
    end
    for (int c = 0; c < 3; c++) begin
      n = c + 1;
      for (int k = 0; k < n; k++) s[k] = msz[c][k];
      f[0] = in_valid && (s[0] < 2);
      d[0] = in_data;
      for (int k = 1; k < n; k++) begin
        f[k] = (s[k-1] > 0) && (s[k] < 2);
        d[k] = mbuf[c][k-1][0];
      end
      f[n] = (s[n-1] > 0) && out_ready;
      for (int k = 1; k <= n; k++)
        if (f[k]) begin
          mbuf[c][k-1][0] = mbuf[c][k-1][1];
          msz[c][k-1]--;
        end
      for (int k = 0; k < n; k++)
        if (f[k]) begin
          mbuf[c][k][msz[c][k]] = d[k];
          msz[c][k]++;
        end
      for (int k = 0; k < n; k++)
        if (msz[c][k] > 0) mlast[c][k] = mbuf[c][k][0];
    end
  endtask

  task automatic compare();
    int n;
    for (int c = 0; c < 3; c++) begin
      n = c + 1;
      check($sformatf("ns%0d_in_ready", n), {31'b0, rdy_a[c]}, {31'b0, msz[c][0] < 2});
      check($sformatf("ns%0d_out_valid", n), {31'b0, ov_a[c]}, {31'b0, msz[c][n-1] > 0});
      check($sformatf("ns%0d_occupancy", n), occ_a[c], model_occ(c));
      check($sformatf("ns%0d_out_data", n), od_a[c], mlast[c][n-1]);
    end
  endtask

  always @(posedge rst) model_clear(rst_val);

  // Edge process: record output beats, advance the model, then compare.
  always @(posedge clk) begin
    if (ov_a[1] && out_ready) got2.push_back(od_a[1]);
    for (int c = 0; c < 3; c++)
      if (ov_a[c] && out_ready && od_a[c] == 32'h55) seen55 = 1'b1;
    if (!rst) model_step();
    #2;
    if (chk_en) compare();
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s_ns%0d_out_valid", tag, c+1), {31'b0, ov_a[c]}, 32'd0);
      check($sformatf("%s_ns%0d_in_ready", tag, c+1), {31'b0, rdy_a[c]}, 32'd1);
      check($sformatf("%s_ns%0d_occupancy", tag, c+1), occ_a[c], 32'd0);
      check($sformatf("%s_ns%0d_out_data", tag, c+1), od_a[c], 32'h0000_DEAD);
    end
  endtask

  initial begin
    int pin;
    int pout;
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    chk_en = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Streaming with no backpressure.
    got2.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd1;
    cyc(1);
    check("lat_early_ns2", {31'b0, ov_a[1]}, 32'd0);
    in_data = 32'd2;
    cyc(1);
    check("lat_ontime_ns2", {31'b0, ov_a[1]}, 32'd1);
    check("lat_data_ns2", od_a[1], 32'd1);
    for (int i = 3; i <= 16; i++) begin
      in_data = i;
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(4);
    check("stream_count_ns2", got2.size(), 32'd16);
    for (int i = 0; i < got2.size() && i < 16; i++)
      check($sformatf("stream_beat%0d_ns2", i), got2[i], i + 1);

    // Backpressure: fill to capacity, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + i;
      cyc(1);
    end
    in_valid = 1'b0;
    check("bp_occ_ns2", occ_a[1], 32'd4);
    check("bp_ready_ns2", {31'b0, rdy_a[1]}, 32'd0);
    check("bp_model_occ_ns2", model_occ(1), 32'd4);
    got2.delete();
    out_ready = 1'b1;
    cyc(6);
    check("drain_count_ns2", got2.size(), 32'd4);
    for (int i = 0; i < got2.size() && i < 4; i++)
      check($sformatf("drain_beat%0d_ns2", i), got2[i], 32'h100 + i);

    // Flush with three beats held and a beat offered in the flush cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h200 + i;
      cyc(1);
    end
    in_valid = 1'b0;
    check("preflush_occ_ns2", occ_a[1], 32'd3);
    in_valid = 1'b1;
    in_data  = 32'h55;
    flush    = 1'b1;
    cyc(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_occ_ns2", occ_a[1], 32'd0);
    check("flush_valid_ns2", {31'b0, ov_a[1]}, 32'd0);
    check("flush_data_ns2", od_a[1], 32'hF1F1_0000);
    check("flush_ready_ns2", {31'b0, rdy_a[1]}, 32'd1);
    seen55    = 1'b0;
    out_ready = 1'b1;
    cyc(6);
    check("flush_dropped_55", {31'b0, seen55}, 32'd0);

    // Random traffic, with a mid-traffic asynchronous reset.
    pin  = 70;
    pout = 70;
    for (int cy = 0; cy < 10000; cy++) begin
      if (cy % 1000 == 0) begin
        pin  = $urandom_range(10, 100);
        pout = $urandom_range(10, 100);
      end
      in_valid  = ($urandom_range(0, 99) < pin);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 99) < pout);
      flush     = ($urandom_range(0, 499) == 0);
      if (cy == 5000) begin
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cyc(1);
        rst = 1'b0;
      end
      cyc(1);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc(10);
    check("final_occ_ns3", occ_a[2], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
